// File: rtl/mp_add_pkg.sv
// Shared types and helpers for the multi-precision add sequencer.
package mp_add_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mp_add_state_e;

  // Word index width; a single-word configuration still needs one bit.
  function automatic int idx_width(input int num_words);
    return (num_words <= 1) ? 1 : $clog2(num_words);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Narrow BIT_WIDTH-bit full adder, shared across words by the sequencer.
module full_adder #(
  parameter int BIT_WIDTH = 4
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, cin};

endmodule

// File: rtl/mp_add_sequencer.sv
// Multi-precision add sequencer: adds two NUM_WORDS*BIT_WIDTH-bit operands
// one word per cycle (LSW first) through a single full_adder.
// Optional macro MP_ADD_SEQUENCER_SUB_EN adds a 'sub' input that turns the
// operation into a - b (b inverted, carry-in forced to 1; cout=1 = no borrow).
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | one word added per clock, idx selects the current word
module mp_add_sequencer
  import mp_add_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int NUM_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
`ifdef MP_ADD_SEQUENCER_SUB_EN
  input  logic                           sub,
`endif
  input  logic [BIT_WIDTH*NUM_WORDS-1:0] a,
  input  logic [BIT_WIDTH*NUM_WORDS-1:0] b,
  input  logic                           cin,
  output logic                           busy,
  output logic                           done,
  output logic [BIT_WIDTH*NUM_WORDS-1:0] sum,
  output logic                           cout
);

  localparam int TOTAL = BIT_WIDTH * NUM_WORDS;
  localparam int IW    = idx_width(NUM_WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

  mp_add_state_e state_q, state_d;
  logic [TOTAL-1:0] a_sh_q, a_sh_d;
  logic [TOTAL-1:0] b_sh_q, b_sh_d;
  logic [TOTAL-1:0] res_sh_q, res_sh_d;
  logic [TOTAL-1:0] sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic [BIT_WIDTH-1:0] fa_sum;
  logic                 fa_cout;
  logic [TOTAL-1:0]     res_next;
  logic [TOTAL-1:0]     b_in;
  logic                 cin_in;

`ifdef MP_ADD_SEQUENCER_SUB_EN
  assign b_in   = sub ? ~b : b;
  assign cin_in = sub ? 1'b1 : cin;
`else
  assign b_in   = b;
  assign cin_in = cin;
`endif

  full_adder #(.BIT_WIDTH(BIT_WIDTH)) u_full_adder (
    .a    (a_sh_q[BIT_WIDTH-1:0]),
    .b    (b_sh_q[BIT_WIDTH-1:0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New sum word enters at the top; after NUM_WORDS shifts the LSW sits at bit 0.
  generate
    if (NUM_WORDS == 1) begin : g_res_single
      assign res_next = fa_sum;
    end else begin : g_res_multi
      assign res_next = {fa_sum, res_sh_q[TOTAL-1:BIT_WIDTH]};
    end
  endgenerate

  // Next-state, datapath shifting and completion decode.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    sum_d    = sum_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b_in;
          carry_d = cin_in;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> BIT_WIDTH;
        b_sh_d   = b_sh_q >> BIT_WIDTH;
        res_sh_d = res_next;
        carry_d  = fa_cout;
        if (idx_q == LAST_IDX) begin
          sum_d   = res_next;
          cout_d  = fa_cout;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      sum_q    <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      sum_q    <= sum_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed bench for mp_add_sequencer: a 4x4-bit instance and a 1-word instance.
module tb_mp_add_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic sub;

  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic        busy, done, cout;
  logic [15:0] sum;

  logic       start1;
  logic [3:0] a1, b1;
  logic       cin1;
  logic       busy1, done1, cout1;
  logic [3:0] sum1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] prev_sum;

  always #5 clk = ~clk;

  mp_add_sequencer #(.BIT_WIDTH(4), .NUM_WORDS(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef MP_ADD_SEQUENCER_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  mp_add_sequencer #(.BIT_WIDTH(4), .NUM_WORDS(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
`ifdef MP_ADD_SEQUENCER_SUB_EN
    .sub   (sub),
`endif
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation: start pulse, 4 RUN cycles, done cycle, then idle cycle.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input logic [15:0] exp_sum, input logic exp_cout);
    a = av; b = bv; cin = cv; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk({tag, " busy"}, busy, 1'b1);
      chk({tag, " done low"}, done, 1'b0);
      chk({tag, " sum held"}, sum, prev_sum);
      if (k < 3) tick();
      else begin
        a = ~av; b = ~bv; cin = ~cv;
        tick();
      end
    end
    chk({tag, " done"}, done, 1'b1);
    chk({tag, " busy end"}, busy, 1'b0);
    chk({tag, " sum"}, sum, exp_sum);
    chk({tag, " cout"}, cout, exp_cout);
    tick();
    chk({tag, " done pulse"}, done, 1'b0);
    prev_sum = exp_sum;
  endtask

  initial begin
    rst_n = 1'b0; sub = 1'b0;
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    prev_sum = '0;
    #12;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst sum", sum, 16'h0000);
    chk("rst cout", cout, 1'b0);
    chk("rst busy1", busy1, 1'b0);
    rst_n = 1'b1;
    tick();

    run_op("add1234", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
    run_op("rippleB", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_op("rippleC", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);

    // start held high: one op every 5 cycles, mid-RUN input changes ignored
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    tick();
    for (int op = 0; op < 2; op++) begin
      for (int k = 0; k < 4; k++) begin
        chk("hold busy", busy, 1'b1);
        chk("hold done low", done, 1'b0);
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        tick();
      end
      chk("hold done", done, 1'b1);
      chk("hold busy end", busy, 1'b0);
      chk("hold sum", sum, 16'h0100);
      chk("hold cout", cout, 1'b0);
      a = 16'h00FF; b = 16'h0001; cin = 1'b0;
      if (op == 1) start = 1'b0;
      tick();
    end
    chk("hold stop", busy, 1'b0);
    prev_sum = 16'h0100;

    // reset in the third RUN cycle
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("abort pre busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort sum", sum, 16'h0000);
    chk("abort cout", cout, 1'b0);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort no done", done, 1'b0);
    end
    prev_sum = 16'h0000;
    run_op("post rst", 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0);

    // single-word instance
    a1 = 4'hF; b1 = 4'h1; cin1 = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("nw1 busy", busy1, 1'b1);
    chk("nw1 done low", done1, 1'b0);
    tick();
    chk("nw1 done", done1, 1'b1);
    chk("nw1 busy end", busy1, 1'b0);
    chk("nw1 sum", sum1, 4'h0);
    chk("nw1 cout", cout1, 1'b1);
    tick();
    chk("nw1 done pulse", done1, 1'b0);

`ifdef MP_ADD_SEQUENCER_SUB_EN
    sub = 1'b1;
    run_op("sub5-7", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
    run_op("sub7-5", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
    sub = 1'b0;
    run_op("sub off", 16'h0007, 16'h0005, 1'b0, 16'h000C, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
